// File: rtl/bf16_add_arbiter_if.sv
// ----------------------------------------------------------------------------
// bf16_add_arbiter_if
//   Bundles the requester-side and adder-side signals of bf16_add_arbiter.
//   The slave modport is the arbiter's view. The master modport is the view
//   of the surrounding logic: the requesters plus the shared add_bf16 adder.
//
//   flush       sync clear of in-flight tags and response slots
//   req_*       per-requester operand handshake (16 bits per bf16 slot)
//   resp_*      per-requester response slots
//                 resp_flags slot = {invalid, underflow, overflow}
//   add_*       operand/result path to the shared pipelined adder
//   busy        any op in flight or any response slot occupied
// ----------------------------------------------------------------------------
interface bf16_add_arbiter_if #(
    parameter int N_REQ = 4
);
    logic                   flush;
    logic [N_REQ-1:0]       req_valid;
    logic [16*N_REQ-1:0]    req_a;
    logic [16*N_REQ-1:0]    req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       resp_valid;
    logic [N_REQ-1:0]       resp_ready;
    logic [16*N_REQ-1:0]    resp_data;
    logic [3*N_REQ-1:0]     resp_flags;
    logic [15:0]            add_a;
    logic [15:0]            add_b;
    logic [15:0]            add_sum;
    logic                   add_ovf;
    logic                   add_unf;
    logic                   add_inv;
    logic                   busy;

    modport slave (
        input  flush, req_valid, req_a, req_b, resp_ready,
               add_sum, add_ovf, add_unf, add_inv,
        output req_ready, resp_valid, resp_data, resp_flags,
               add_a, add_b, busy
    );

    modport master (
        output flush, req_valid, req_a, req_b, resp_ready,
               add_sum, add_ovf, add_unf, add_inv,
        input  req_ready, resp_valid, resp_data, resp_flags,
               add_a, add_b, busy
    );
endinterface

// File: rtl/bf16_add_arbiter.sv
// ----------------------------------------------------------------------------
// bf16_add_arbiter
//   Shares one pipelined bf16 adder between N_REQ requesters. Each cycle at
//   most one eligible request is granted, round-robin from rr_ptr. Its
//   operands are steered onto the adder, and a tag {valid, id, invalid} follows
//   the op down a pipe that matches the adder latency. When the tag leaves
//   the pipe, the adder result is written into the requester's response slot.
//   Each requester has at most one op outstanding: one that is in flight or
//   sitting in its response slot.
//
// Ports
//   clk          rising-edge clock
//   RST          asynchronous active-high reset
//   bus.slave    flush, req_valid/req_a/req_b -> req_ready (one-hot grant),
//                resp_valid/resp_data/resp_flags <- resp_ready,
//                add_a/add_b -> adder, add_sum/add_ovf/add_unf/add_inv <- adder,
//                busy
//
// Parameters
//   N_REQ        number of requesters (>= 2)
//   ADD_LATENCY  cycles from the operands being driven to the adder outputs
//                becoming valid
// ----------------------------------------------------------------------------
module bf16_add_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              RST,
    bf16_add_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Arbitration
    logic [N_REQ-1:0]                 elig;
    logic                             grant_any;
    logic [ID_W-1:0]                  grant_idx;
    logic [N_REQ-1:0]                 grant_oh;
    logic [ID_W-1:0]                  scan_id;
    logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;

    // Operand steering
    logic [15:0]                      add_a_c, add_b_c;

    // Tag pipe: one entry per adder stage
    logic [ADD_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [ADD_LATENCY-1:0][ID_W-1:0] tag_id_q,  tag_id_d;
    logic [ADD_LATENCY-1:0]           tag_inv_q, tag_inv_d;

    // Per-requester state
    logic [N_REQ-1:0]                 inflight_q,   inflight_d;
    logic [N_REQ-1:0]                 resp_valid_q, resp_valid_d;
    logic [16*N_REQ-1:0]              resp_data_q,  resp_data_d;
    logic [3*N_REQ-1:0]               resp_flags_q, resp_flags_d;

    // Capture, taken from the last tag stage
    logic                             cap_vld;
    logic [ID_W-1:0]                  cap_id;
    logic                             cap_inv;

    // A requester competes only if it has no op in flight, its slot is empty,
    // and neither flush nor reset is active. Gating on RST makes req_ready
    // drop the moment reset is asserted, without waiting for an edge.
    assign elig = bus.req_valid & ~inflight_q & ~resp_valid_q
                & {N_REQ{~bus.flush & ~RST}};

    // Round-robin scan starting at rr_ptr; the first eligible index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        scan_id   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_id = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_any && elig[scan_id]) begin
                grant_any = 1'b1;
                grant_idx = scan_id;
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // The pointer moves just past the winner, so the winner has the lowest
    // priority next time. With no grant, the pointer holds.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            if (grant_idx == ID_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
        end
    end

    // One-hot mux onto the adder. When nothing is granted, zeros are driven so
    // the adder sees a quiet 0+0 and add_inv stays low.
    always_comb begin
        add_a_c = 16'h0000;
        add_b_c = 16'h0000;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                add_a_c = bus.req_a[16*i +: 16];
                add_b_c = bus.req_b[16*i +: 16];
            end
        end
    end

    // Tag pipe. add_inv comes combinationally from the operands the adder is
    // sampling now, so it is captured at issue. The adder does not carry it
    // alongside the sum.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_inv_d    = tag_inv_q;
        tag_vld_d[0] = grant_any;
        tag_id_d[0]  = grant_idx;
        tag_inv_d[0] = grant_any & bus.add_inv;
        for (int s = 1; s < ADD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
            tag_inv_d[s] = tag_inv_q[s-1];
        end
        if (bus.flush) begin
            tag_vld_d = '0;
        end
    end

    // The last tag stage lines up with the adder outputs. A flush on the same
    // edge discards the result.
    assign cap_vld = tag_vld_q[ADD_LATENCY-1] & ~bus.flush;
    assign cap_id  = tag_id_q[ADD_LATENCY-1];
    assign cap_inv = tag_inv_q[ADD_LATENCY-1];

    // Slot update. A capture and a drain never hit the same slot on one edge,
    // because a full slot blocks issue for that requester. Data and flags keep
    // their last captured value after a drain or a flush.
    always_comb begin
        inflight_d   = inflight_q;
        resp_valid_d = resp_valid_q & ~bus.resp_ready;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (cap_vld && (cap_id == ID_W'(i))) begin
                inflight_d[i]          = 1'b0;
                resp_valid_d[i]        = 1'b1;
                resp_data_d[16*i +: 16] = bus.add_sum;
                resp_flags_d[3*i +: 3]  = {cap_inv, bus.add_unf, bus.add_ovf};
            end
            if (grant_oh[i]) begin
                inflight_d[i] = 1'b1;
            end
        end
        if (bus.flush) begin
            inflight_d   = '0;
            resp_valid_d = '0;
        end
    end

    // ---- register boundary: issue edge / capture edge ----
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            tag_inv_q    <= '0;
            inflight_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            tag_inv_q    <= tag_inv_d;
            inflight_q   <= inflight_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign bus.req_ready  = grant_oh;
    assign bus.add_a      = add_a_c;
    assign bus.add_b      = add_b_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_flags = resp_flags_q;
    assign bus.busy       = (|inflight_q) | (|resp_valid_q);

endmodule
